// File: rtl/game_pkg.sv
// Shared game types: screen-select modes, encounter controller states, screen origin.
package game_pkg;

  typedef enum logic [1:0] {
    OVERWORLD = 2'd0,
    FLASH     = 2'd1,
    BATTLE    = 2'd2,
    GAME_OVER = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_OVERWORLD,
    ST_FLASH,
    ST_INIT,
    ST_BATTLE,
    ST_RESULT,
    ST_GAME_OVER
  } enc_state_t;

  localparam int SCREEN_X0 = 432;
  localparam int SCREEN_Y0 = 312;

  // The battle subtracts damage without saturating, so anything above max wrapped below zero.
  function automatic logic [7:0] returned_health(input logic [7:0] h, input logic [7:0] max_h);
    return (h > max_h) ? 8'd0 : h;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// One-cycle pulse marking the start of a frame, registered from the raster position.
module frame_tick (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic        tick_out
);

  logic tick_d;
  logic tick_q;

  always_comb begin
    tick_d = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) tick_q <= 1'b0;
    else        tick_q <= tick_d;
  end

  assign tick_out = tick_q;

endmodule

// File: rtl/encounter_ctrl.sv
// Overworld-side encounter controller: triggers wild battles, runs the flash transition,
// drives the battle handshake and owns the player health register.
module encounter_ctrl
  import game_pkg::*;
#(
  parameter logic [7:0] MAX_HEALTH       = 8'd100,
  parameter logic [7:0] ENCOUNTER_THRESH = 8'd40,
  parameter logic [7:0] COOLDOWN_STEPS   = 8'd4,
  parameter logic [7:0] FLASH_FRAMES     = 8'd16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        step_in,
  input  logic        grass_in,
  input  logic [7:0]  rand_in,
  input  logic        respawn_in,
  input  logic        battle_run_in,
  input  logic [7:0]  battle_health_in,
  output logic        battle_rst_out,
  output logic        battle_start_out,
  output logic [7:0]  battle_health_out,
  output logic [1:0]  mode_out,
  output logic        flash_out,
  output logic [7:0]  player_health_out
);

  logic tick;

  frame_tick u_frame_tick (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .hcount_in (hcount_in),
    .vcount_in (vcount_in),
    .tick_out  (tick)
  );

  enc_state_t state_d, state_q;
  mode_t      mode_d, mode_q;
  logic [7:0] player_d, player_q;
  logic [7:0] cool_d, cool_q;
  logic [7:0] frames_d, frames_q;
  logic [7:0] frames_inc;
  logic [7:0] cap_d, cap_q;
  logic [7:0] bhealth_d, bhealth_q;
  logic [7:0] res_h;
  logic       flash_d, flash_q;
  logic       brst_d, brst_q;
  logic       bstart_d, bstart_q;
  logic       first_d, first_q;

  // Handshake: battle_rst_out pulses one cycle with battle_health_out valid, then
  // battle_start_out holds high until a battle_run_in pulse (ignored on the first cycle).
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    player_d   = player_q;
    cool_d     = cool_q;
    frames_d   = frames_q;
    cap_d      = cap_q;
    bhealth_d  = bhealth_q;
    flash_d    = flash_q;
    brst_d     = brst_q;
    bstart_d   = bstart_q;
    first_d    = first_q;
    frames_inc = frames_q + 8'd1;
    res_h      = returned_health(cap_q, MAX_HEALTH);

    unique case (state_q)
      ST_OVERWORLD: begin
        if (step_in && grass_in) begin
          if (cool_q != 8'd0) begin
            cool_d = cool_q - 8'd1;
          end else if (rand_in < ENCOUNTER_THRESH) begin
            state_d  = ST_FLASH;
            mode_d   = FLASH;
            frames_d = 8'd0;
            flash_d  = 1'b0;
          end
        end
      end
      ST_FLASH: begin
        if (tick) begin
          frames_d = frames_inc;
          flash_d  = frames_inc[2];
          if (frames_inc == FLASH_FRAMES) begin
            state_d   = ST_INIT;
            mode_d    = BATTLE;
            flash_d   = 1'b0;
            brst_d    = 1'b1;
            bhealth_d = player_q;
          end
        end
      end
      ST_INIT: begin
        brst_d   = 1'b0;
        bstart_d = 1'b1;
        first_d  = 1'b1;
        state_d  = ST_BATTLE;
      end
      ST_BATTLE: begin
        first_d = 1'b0;
        if (battle_run_in && !first_q) begin
          cap_d    = battle_health_in;
          bstart_d = 1'b0;
          state_d  = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_h == 8'd0) begin
          player_d = 8'd0;
          state_d  = ST_GAME_OVER;
          mode_d   = GAME_OVER;
        end else begin
          player_d = res_h;
          cool_d   = COOLDOWN_STEPS;
          state_d  = ST_OVERWORLD;
          mode_d   = OVERWORLD;
          flash_d  = 1'b0;
        end
      end
      ST_GAME_OVER: begin
        if (respawn_in) begin
          player_d = MAX_HEALTH;
          cool_d   = COOLDOWN_STEPS;
          state_d  = ST_OVERWORLD;
          mode_d   = OVERWORLD;
        end
      end
      default: begin
        state_d = ST_OVERWORLD;
        mode_d  = OVERWORLD;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_OVERWORLD;
      mode_q    <= OVERWORLD;
      player_q  <= MAX_HEALTH;
      cool_q    <= 8'd0;
      frames_q  <= 8'd0;
      cap_q     <= 8'd0;
      bhealth_q <= MAX_HEALTH;
      flash_q   <= 1'b0;
      brst_q    <= 1'b0;
      bstart_q  <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      player_q  <= player_d;
      cool_q    <= cool_d;
      frames_q  <= frames_d;
      cap_q     <= cap_d;
      bhealth_q <= bhealth_d;
      flash_q   <= flash_d;
      brst_q    <= brst_d;
      bstart_q  <= bstart_d;
      first_q   <= first_d;
    end
  end

  assign battle_rst_out    = brst_q;
  assign battle_start_out  = bstart_q;
  assign battle_health_out = bhealth_q;
  assign mode_out          = mode_q;
  assign flash_out         = flash_q;
  assign player_health_out = player_q;

endmodule

// File: tb/tb_encounter_ctrl.sv
// Bench for encounter_ctrl: directed scenarios then random stimulus against a behavioural model.
module tb_encounter_ctrl;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = 11'd5;
  logic [9:0]  vcount_in = 10'd5;
  logic        step_in = 1'b0, grass_in = 1'b0, respawn_in = 1'b0, battle_run_in = 1'b0;
  logic [7:0]  rand_in = 8'd255, battle_health_in = 8'd0;
  logic        battle_rst_out, battle_start_out, flash_out;
  logic [7:0]  battle_health_out, player_health_out;
  logic [1:0]  mode_out;

  always #5 clk = ~clk;

  encounter_ctrl dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .step_in           (step_in),
    .grass_in          (grass_in),
    .rand_in           (rand_in),
    .respawn_in        (respawn_in),
    .battle_run_in     (battle_run_in),
    .battle_health_in  (battle_health_in),
    .battle_rst_out    (battle_rst_out),
    .battle_start_out  (battle_start_out),
    .battle_health_out (battle_health_out),
    .mode_out          (mode_out),
    .flash_out         (flash_out),
    .player_health_out (player_health_out)
  );

  int n_vec = 0;
  int n_err = 0;

  // staged inputs for the next cycle
  logic       s_rst, s_step, s_grass, s_resp, s_run, s_tick;
  logic [7:0] s_rand, s_bh;

  // behavioural model
  int m_mode, m_player, m_cool, m_frames, m_flash, m_rst, m_start, m_bh;
  int m_cap, m_result, m_first, m_tick;

  // {mode, flash, rst, start, battle_health, player_health}
  logic [20:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_staged();
    s_rst = 0; s_step = 0; s_grass = 0; s_resp = 0; s_run = 0; s_tick = 0;
    s_rand = 8'd255; s_bh = 8'd0;
  endtask

  task automatic model_step();
    int tick;
    int h;
    tick = m_tick;
    if (s_rst) begin
      m_mode = 0; m_player = 100; m_cool = 0; m_frames = 0; m_flash = 0;
      m_rst = 0; m_start = 0; m_bh = 100; m_result = 0; m_first = 0;
    end else if (m_rst != 0) begin
      m_rst = 0; m_start = 1; m_first = 1;
    end else if (m_result != 0) begin
      m_result = 0;
      h = (m_cap > 100) ? 0 : m_cap;
      if (h == 0) begin
        m_player = 0; m_mode = 3;
      end else begin
        m_player = h; m_cool = 4; m_mode = 0; m_flash = 0;
      end
    end else begin
      case (m_mode)
        0: if (s_step && s_grass) begin
             if (m_cool > 0) m_cool--;
             else if (s_rand < 40) begin m_mode = 1; m_frames = 0; m_flash = 0; end
           end
        1: if (tick != 0) begin
             m_frames++;
             m_flash = (m_frames / 4) % 2;
             if (m_frames == 16) begin
               m_mode = 2; m_flash = 0; m_rst = 1; m_bh = m_player;
             end
           end
        2: begin
             if (m_first == 0 && s_run) begin
               m_cap = s_bh; m_result = 1; m_start = 0;
             end
             m_first = 0;
           end
        default: if (s_resp) begin m_player = 100; m_cool = 4; m_mode = 0; end
      endcase
    end
    m_tick = (!s_rst && hcount_in == 0 && vcount_in == 0) ? 1 : 0;
    exp_q.push_back({2'(m_mode), 1'(m_flash), 1'(m_rst), 1'(m_start), 8'(m_bh), 8'(m_player)});
  endtask

  // drive one cycle of staged inputs; returns with DUT outputs of that edge settled
  task automatic cycle();
    @(negedge clk);
    rst_in = s_rst; step_in = s_step; grass_in = s_grass; rand_in = s_rand;
    respawn_in = s_resp; battle_run_in = s_run; battle_health_in = s_bh;
    if (s_tick) begin
      hcount_in = 11'd0; vcount_in = 10'd0;
    end else begin
      hcount_in = 11'($urandom_range(1, 1599));
      vcount_in = 10'($urandom_range(0, 999));
    end
    model_step();
    @(posedge clk);
    #2;
    clear_staged();
  endtask

  task automatic go_battle();
    for (int i = 0; i < 12 && m_mode != 1; i++) begin
      s_step = 1; s_grass = 1; s_rand = 8'd0;
      cycle();
    end
    for (int i = 0; i < 40 && m_rst == 0; i++) begin
      s_tick = (i % 2 == 0);
      cycle();
    end
    cycle();
  endtask

  // compare process: every cycle the model has produced an expectation for
  initial begin
    logic [20:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mode",          int'(mode_out),          int'(e[20:19]));
        chk("flash",         int'(flash_out),         int'(e[18]));
        chk("battle_rst",    int'(battle_rst_out),    int'(e[17]));
        chk("battle_start",  int'(battle_start_out),  int'(e[16]));
        chk("battle_health", int'(battle_health_out), int'(e[15:8]));
        chk("player_health", int'(player_health_out), int'(e[7:0]));
      end
    end
  end

  initial begin
    clear_staged();
    m_tick = 0;
    s_rst = 1; cycle();
    s_rst = 1; cycle();
    chk("lit_reset_mode", int'(mode_out), 0);
    chk("lit_reset_player", int'(player_health_out), 100);
    chk("lit_reset_bhealth", int'(battle_health_out), 100);
    chk("lit_reset_start", int'(battle_start_out), 0);

    // non-qualifying steps
    s_step = 1; s_grass = 0; s_rand = 8'd10; cycle();
    s_step = 1; s_grass = 1; s_rand = 8'd200; cycle();
    cycle();
    chk("lit_no_trigger_mode", int'(mode_out), 0);

    // encounter and flash
    s_step = 1; s_grass = 1; s_rand = 8'd10; cycle();
    chk("lit_trigger_mode", int'(mode_out), 1);
    for (int i = 0; i < 16; i++) begin
      s_tick = 1; cycle();
      cycle();
      if (i == 3) chk("lit_flash_on_frame4", int'(flash_out), 1);
    end
    chk("lit_rst_pulse", int'(battle_rst_out), 1);
    chk("lit_rst_bhealth", int'(battle_health_out), 100);
    cycle();
    chk("lit_rst_one_cycle", int'(battle_rst_out), 0);
    chk("lit_start_high", int'(battle_start_out), 1);

    // run on first battle cycle is ignored
    s_run = 1; s_bh = 8'd50; cycle();
    chk("lit_first_run_ignored", int'(battle_start_out), 1);
    cycle();
    s_run = 1; s_bh = 8'd70; cycle();
    chk("lit_start_drop", int'(battle_start_out), 0);
    cycle();
    chk("lit_win_mode", int'(mode_out), 0);
    chk("lit_win_player", int'(player_health_out), 70);

    // cooldown: four qualifying steps ignored, fifth triggers
    for (int i = 0; i < 5; i++) begin
      s_step = 1; s_grass = 1; s_rand = 8'd0; cycle();
      if (i == 3) chk("lit_cooldown_mode", int'(mode_out), 0);
      cycle();
    end
    chk("lit_after_cooldown_mode", int'(mode_out), 1);
    s_tick = 1; cycle();
    cycle();
    s_rst = 1; cycle();
    chk("lit_rst_flash_mode", int'(mode_out), 0);
    chk("lit_rst_flash_player", int'(player_health_out), 100);

    // underflowed health leads to game over, then respawn
    go_battle();
    chk("lit_bhealth_handoff", int'(battle_health_out), 100);
    cycle();
    s_run = 1; s_bh = 8'd246; cycle();
    s_step = 1; s_grass = 1; s_rand = 8'd0; cycle();
    chk("lit_over_mode", int'(mode_out), 3);
    chk("lit_over_player", int'(player_health_out), 0);
    s_run = 1; s_step = 1; s_grass = 1; s_rand = 8'd0; cycle();
    s_resp = 1; cycle();
    chk("lit_respawn_mode", int'(mode_out), 0);
    chk("lit_respawn_player", int'(player_health_out), 100);

    // reset in the middle of a battle
    go_battle();
    cycle();
    cycle();
    s_rst = 1; cycle();
    chk("lit_rst_battle_start", int'(battle_start_out), 0);
    chk("lit_rst_battle_mode", int'(mode_out), 0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      s_rst   = ($urandom_range(0, 299) == 0);
      s_tick  = ($urandom_range(0, 2) == 0);
      s_step  = ($urandom_range(0, 2) == 0);
      s_grass = ($urandom_range(0, 1) == 0);
      s_rand  = 8'($urandom_range(0, 255));
      s_resp  = ($urandom_range(0, 9) == 0);
      s_run   = ($urandom_range(0, 7) == 0);
      s_bh    = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 100))
                                            : 8'($urandom_range(0, 255));
      cycle();
    end

    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/encounter_ctrl.md
Name: encounter_ctrl

Overview:
- Overworld-side initiator for the battle screen; it is the counterpart of the battle module.
- Decides when a wild encounter fires, runs a frame-timed flash transition, then drives the battle handshake: init pulse, health hand-off, start level.
- Waits for the battle's run pulse, captures the returned health and routes the game to overworld or game-over.
- Owns the authoritative player health register.

Parameters:
- MAX_HEALTH, 100, player health after reset or respawn; also the upper bound of a valid returned health.
- ENCOUNTER_THRESH, 8'd40, an encounter fires when rand_in < ENCOUNTER_THRESH on a qualifying step.
- COOLDOWN_STEPS, 4, qualifying steps ignored after a battle ends.
- FLASH_FRAMES, 16, length of the transition in frames.

Ports:
- clk_in  in  1  system/pixel clock
- rst_in  in  1  synchronous active-high reset
- hcount_in  in  11  current pixel x; frame tick = (hcount_in==0 && vcount_in==0)
- vcount_in  in  10  current pixel y
- step_in  in  1  one-cycle pulse, player completed a tile move
- grass_in  in  1  player currently on an encounter tile
- rand_in  in  8  free-running LFSR value
- respawn_in  in  1  button, leaves GAME_OVER
- battle_run_in  in  1  battle finished (pulse from battle module)
- battle_health_in  in  8  battle module's health_out
- battle_rst_out  out  1  one-cycle init pulse to the battle module
- battle_start_out  out  1  level, battle active
- battle_health_out  out  8  health handed to battle (health_in)
- mode_out  out  2  screen select: 0 overworld, 1 flash, 2 battle, 3 game over
- flash_out  out  1  invert/white-out toggle during transition
- player_health_out  out  8  registered player health

Behaviour:
- Reset values: state OVERWORLD, player_health = MAX_HEALTH, cooldown = 0, frame count = 0, battle_rst_out = 0, battle_start_out = 0, mode_out = 0, flash_out = 0, battle_health_out = MAX_HEALTH.
- Reset takes priority over every event, including mid-battle: battle_start_out drops the same cycle.
- All outputs are registered.
- OVERWORLD (mode 0):
  - Qualifying step: step_in && grass_in.
  - If cooldown > 0, a qualifying step only decrements cooldown.
  - Else, if rand_in < ENCOUNTER_THRESH, go to FLASH with frame count = 0.
  - step_in without grass_in: no effect.
- FLASH (mode 1):
  - Each frame tick increments the frame count; flash_out toggles every 4 frames (flash_out = count[2]).
  - When the tick makes the count reach FLASH_FRAMES, go to INIT.
- INIT: battle_health_out <= player_health, battle_rst_out = 1 for exactly one cycle, then go to BATTLE.
- BATTLE (mode 2):
  - battle_start_out = 1 from the cycle after the rst pulse.
  - battle_run_in is ignored in the first BATTLE cycle (run is cleared on init).
  - On battle_run_in = 1: capture battle_health_in the same cycle, drop battle_start_out next cycle, go to RESULT.
- RESULT (one cycle):
  - Captured value h > MAX_HEALTH is treated as unsigned underflow (the battle subtracts without saturation), so h becomes 0.
  - If h == 0: player_health = 0, go to GAME_OVER.
  - Otherwise: player_health = h, cooldown = COOLDOWN_STEPS, go to OVERWORLD, flash_out = 0.
- GAME_OVER (mode 3): respawn_in → player_health = MAX_HEALTH, cooldown = COOLDOWN_STEPS, go to OVERWORLD. All other inputs are ignored.
- Simultaneous events:
  - step_in during FLASH, INIT, BATTLE or RESULT is ignored.
  - battle_run_in outside BATTLE is ignored.
  - respawn_in outside GAME_OVER is ignored.
- Latency:
  - Qualifying step to mode 1: 1 cycle.
  - Last flash tick to battle_rst_out: 1 cycle.
  - battle_run_in to mode_out = 0 or 3: 2 cycles.

Decomposition:
- game_pkg holds:
  - mode_t enum (OVERWORLD=0, FLASH=1, BATTLE=2, GAME_OVER=3), shared with the top-level screen mux.
  - enc_state_t enum.
  - SCREEN_X0=432 and SCREEN_Y0=312.
- One sub-module: frame_tick, which registers the hcount/vcount==0 detect into a single-cycle pulse, reusable elsewhere.

Test Plan:
- Reset, then step_in with grass_in=1 and rand_in=10 → mode_out=1 next cycle; after 16 frame ticks, battle_rst_out high exactly 1 cycle with battle_health_out=100; then battle_start_out=1.
- step_in with grass_in=1 and rand_in=200, or with grass_in=0 and rand_in=10 → stays mode 0, no rst pulse.
- In BATTLE, battle_run_in pulse with battle_health_in=70 → start drops, player_health_out=70, mode_out=0 two cycles later; the next 4 qualifying steps with rand_in=0 do not trigger; the 5th does.
- In BATTLE, battle_run_in with battle_health_in=246 (underflow) → player_health_out=0, mode_out=3; respawn_in → player_health_out=100, mode_out=0.
- battle_run_in held high on the first BATTLE cycle only → ignored, battle_start_out stays 1.
- rst_in asserted mid-FLASH and mid-BATTLE → next cycle all outputs at reset values, battle_start_out=0, mode_out=0.
